// File: rtl/bus_periph_bridge.sv
// bus_periph_bridge: single-cycle CPU bus to DRAM and board peripherals.
// Decodes the top 4 KiB page (0xFFFF_F000..0xFFFF_FFFF) into memory-mapped
// peripherals (LED, switches, buttons, 8-digit seven-segment display) and
// passes every other address to DRAM. Reads are purely combinational.
// Optional timer (TIMER_CNT / TIMER_DIV) is built only when the macro
// TIMER_PERIPH_EN is defined; otherwise those addresses read 0.
module bus_periph_bridge #(
  parameter int SCAN_DIV = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr_i,
  input  logic        wen_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [13:0] dram_addr_o,
  output logic        dram_wen_o,
  output logic [31:0] dram_wdata_o,
  input  logic [31:0] dram_rdata_i,
  input  logic [23:0] sw_i,
  input  logic [4:0]  btn_i,
  output logic [23:0] led_o,
  output logic [7:0]  dig_en_o,
  output logic [7:0]  dig_seg_o
);

  localparam logic [31:0] ADDR_DIG       = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_TIMER_CNT = 32'hFFFF_F020;
  localparam logic [31:0] ADDR_TIMER_DIV = 32'hFFFF_F024;
  localparam logic [31:0] ADDR_LED       = 32'hFFFF_F060;
  localparam logic [31:0] ADDR_SW        = 32'hFFFF_F070;
  localparam logic [31:0] ADDR_BTN       = 32'hFFFF_F078;

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  // Hex nibble to active-low segment pattern {DP,G,F,E,D,C,B,A}, DP off.
  function automatic logic [7:0] seg_glyph(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

  logic              is_periph;
  logic              wr_periph;
  logic [23:0]       led_reg;
  logic [31:0]       dig_reg;
  logic [23:0]       sw_sync_p0;
  logic [23:0]       sw_sync_p1;
  logic [4:0]        btn_sync_p0;
  logic [4:0]        btn_sync_p1;
  logic [SCAN_W-1:0] scan_cnt;
  logic [2:0]        dig_idx;
  logic [3:0]        dig_nib;

  assign is_periph = (addr_i[31:12] == 20'hFFFFF);
  assign wr_periph = wen_i & is_periph;

  assign dram_addr_o  = addr_i[15:2];
  assign dram_wdata_o = wdata_i;
  assign dram_wen_o   = wen_i & ~is_periph;

  // Two-flop synchronizers for the asynchronous board inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_sync_p0  <= '0;
      sw_sync_p1  <= '0;
      btn_sync_p0 <= '0;
      btn_sync_p1 <= '0;
    end else begin
      sw_sync_p0  <= sw_i;
      sw_sync_p1  <= sw_sync_p0;
      btn_sync_p0 <= btn_i;
      btn_sync_p1 <= btn_sync_p0;
    end
  end

  // LED and display registers, written directly by the CPU.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_reg <= '0;
      dig_reg <= '0;
    end else if (wr_periph) begin
      if (addr_i == ADDR_LED) led_reg <= wdata_i[23:0];
      if (addr_i == ADDR_DIG) dig_reg <= wdata_i;
    end
  end

  // Display scan: each digit is held for SCAN_DIV cycles, then the next one.
  // CPU writes to DIG deliberately leave the scan position untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      dig_idx  <= dig_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign dig_nib   = dig_reg[{dig_idx, 2'b00} +: 4];
  assign dig_en_o  = ~(8'h01 << dig_idx);
  assign dig_seg_o = seg_glyph(dig_nib);
  assign led_o     = led_reg;

`ifdef TIMER_PERIPH_EN
  logic [31:0] timer_cnt;
  logic [31:0] timer_div;
  logic [31:0] timer_pre;
  logic        timer_tick;
  logic        wr_timer_cnt;
  logic        wr_timer_div;

  assign timer_tick   = (timer_pre == timer_div);
  assign wr_timer_cnt = wr_periph && (addr_i == ADDR_TIMER_CNT);
  assign wr_timer_div = wr_periph && (addr_i == ADDR_TIMER_DIV);

  // Prescaled timer; a CPU write to the count wins over a same-cycle tick,
  // and any write to the timer restarts the prescaler.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_cnt <= '0;
      timer_div <= '0;
      timer_pre <= '0;
    end else begin
      if (wr_timer_cnt)    timer_cnt <= wdata_i;
      else if (timer_tick) timer_cnt <= timer_cnt + 32'd1;

      if (wr_timer_div) timer_div <= wdata_i;

      if (wr_timer_cnt || wr_timer_div || timer_tick) timer_pre <= '0;
      else                                            timer_pre <= timer_pre + 32'd1;
    end
  end
`endif

  // Zero-latency read mux so a single-cycle CPU sees data in the same cycle.
  always_comb begin
    rdata_o = '0;
    if (!is_periph) begin
      rdata_o = dram_rdata_i;
    end else begin
      case (addr_i)
        ADDR_DIG:       rdata_o = dig_reg;
        ADDR_LED:       rdata_o = {8'h00, led_reg};
        ADDR_SW:        rdata_o = {8'h00, sw_sync_p1};
        ADDR_BTN:       rdata_o = {27'h0, btn_sync_p1};
`ifdef TIMER_PERIPH_EN
        ADDR_TIMER_CNT: rdata_o = timer_cnt;
        ADDR_TIMER_DIV: rdata_o = timer_div;
`endif
        default:        rdata_o = '0;
      endcase
    end
  end

endmodule

// File: doc/bus_periph_bridge.md
BUS_PERIPH_BRIDGE -- requirements
Module: bus_periph_bridge

Interface
REQ-001 Parameter SCAN_DIV, default 20000: clk cycles each seven-segment digit is driven.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 addr_i  input  32  byte address from CPU bus master.
REQ-005 wen_i  input  1  CPU write enable.
REQ-006 wdata_i  input  32  CPU write data.
REQ-007 rdata_o  output  32  read data returned to CPU.
REQ-008 dram_addr_o  output  14  DRAM word address, addr_i[15:2].
REQ-009 dram_wen_o  output  1  DRAM write enable.
REQ-010 dram_wdata_o  output  32  DRAM write data, equal to wdata_i.
REQ-011 dram_rdata_i  input  32  DRAM combinational read data.
REQ-012 sw_i  input  24  board switches, asynchronous.
REQ-013 btn_i  input  5  board buttons, asynchronous.
REQ-014 led_o  output  24  LED drive, active-high.
REQ-015 dig_en_o  output  8  digit select, active-low one-hot.
REQ-016 dig_seg_o  output  8  segments {DP,G,F,E,D,C,B,A}, active-low.

Function
REQ-017 Address map SHALL be: 0xFFFF_F000 DIG (R/W); 0xFFFF_F020 TIMER_CNT (R/W); 0xFFFF_F024 TIMER_DIV (R/W); 0xFFFF_F060 LED (R/W); 0xFFFF_F070 SW (R); 0xFFFF_F078 BTN (R); every other address below 0xFFFF_F000 is DRAM.
REQ-018 Addresses ≥0xFFFF_F000 not listed SHALL read 0 and ignore writes.
REQ-019 dram_wen_o SHALL equal wen_i only for DRAM addresses, else 0.
REQ-020 Read path SHALL be combinational (zero-cycle latency) so a single-cycle CPU samples rdata_o in the same cycle.
REQ-021 Register writes SHALL take effect at the rising edge where wen_i=1; read in the next cycle returns new value.
REQ-022 SW reads SHALL return {8'h0, sw_sync}; BTN reads {27'h0, btn_sync}; sync values pass a 2-flop synchronizer (2-cycle latency from pin).
REQ-023 LED reads SHALL return {8'h0, led_reg}; led_o = led_reg = wdata_i[23:0] on write.
REQ-024 Scan counter SHALL count 0..SCAN_DIV-1; on terminal count, wrap to 0 and digit index advances 0→7, 7 wraps to 0.
REQ-025 dig_en_o SHALL drive low only bit [digit index]; dig_seg_o SHALL show hex nibble dig_reg[4*idx+3:4*idx] (0-F glyphs), DP off (1).
REQ-026 Write to DIG SHALL not reset scan counter or digit index; new value visible on current digit next cycle.
REQ-027 Timer prescaler SHALL count 0..TIMER_DIV; when prescaler equals TIMER_DIV, TIMER_CNT increments (wrapping 0xFFFF_FFFF→0) and prescaler clears; TIMER_DIV=0 increments every cycle.
REQ-028 Write to TIMER_CNT in an increment cycle SHALL win (written value loaded, no increment); it also clears prescaler.
REQ-029 Write to TIMER_DIV SHALL clear prescaler.

Reset
REQ-030 With rst_n=0 at a rising edge: led_reg, dig_reg, TIMER_CNT, TIMER_DIV, prescaler, scan counter, digit index, synchronizers SHALL be 0.
REQ-031 After reset: led_o=0, dig_en_o=8'hFE, dig_seg_o=8'hC0 (glyph 0).
REQ-032 Reset asserted mid-scan or mid-prescale SHALL override any concurrent write in that cycle.
REQ-033 Outputs SHALL be combinational from reset-cleared state; no reset dependence on dram_rdata_i.

Configuration
REQ-034 Macro TIMER_PERIPH_EN: defined -> timer registers per REQ-027..029; undefined -> TIMER_CNT/TIMER_DIV absent, read 0, writes ignored, no timer logic synthesized.

Verification
REQ-035 Write 0x00AB_CDEF to 0xFFFF_F060 -> next cycle led_o=24'hABCDEF, read returns 0x00AB_CDEF, dram_wen_o stayed 0.
REQ-036 Write 0x1234_5678 to 0x0000_0010 -> dram_wen_o=1, dram_addr_o=14'h004, dram_wdata_o=0x1234_5678; dram_rdata_i=0xDEAD_BEEF on read -> rdata_o=0xDEAD_BEEF same cycle.
REQ-037 SCAN_DIV=4, DIG=0x0000_00A1 -> digit 0 for 4 cycles dig_en_o=FE, seg=F9 ("1"); then FD, seg=88 ("A"); after 32 cycles back to FE.
REQ-038 sw_i changes 0→0x00_0055 -> SW read returns 0 for 2 edges, 0x0000_0055 from third cycle.
REQ-039 TIMER_PERIPH_EN, TIMER_DIV=2 -> TIMER_CNT increments every 3 cycles; write 0xFFFF_FFFF then 3 cycles -> reads 0; write 5 on an increment cycle -> reads 5.
REQ-040 Assert rst_n=0 mid-operation with wen_i=1 to LED -> led_o=0, dig_en_o=FE, TIMER_CNT=0 after edge.
